// File: rtl/record_song_if.sv
// Audio-in FIFO pop interface and sample-RAM write port seen by the recorder.
interface record_song_if #(
    parameter int unsigned ADDR_W = 16
) ();
    logic              audio_in_available;
    logic [31:0]       left_channel_audio_in;
    logic [31:0]       right_channel_audio_in;
    logic              read_audio_in;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_data;
    logic              mem_wren;

    modport slave (
        input  audio_in_available, left_channel_audio_in, right_channel_audio_in,
        output read_audio_in, mem_address, mem_data, mem_wren
    );

    modport master (
        output audio_in_available, left_channel_audio_in, right_channel_audio_in,
        input  read_audio_in, mem_address, mem_data, mem_wren
    );
endinterface

// File: rtl/record_song.sv
// Records mixed audio-in samples into a sample RAM with level-triggered start,
// pause, early stop and peak-magnitude tracking.
module record_song #(
    parameter int unsigned ADDR_W    = 16,
    parameter logic [31:0] THRESHOLD = 32'h0010_0000,
    parameter bit          MONO_MIX  = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_pause,
    record_song_if.slave      io_bus,
    output logic              o_recording,
    output logic              o_done,
    output logic [ADDR_W:0]   o_sample_count,
    output logic [31:0]       o_peak
);
    typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDone} state_e;

    state_e              r_state, w_state_next;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   r_mem_address;
    logic [31:0]         r_mem_data;
    logic                r_mem_wren;
    logic [ADDR_W:0]     r_count;
    logic [31:0]         r_peak;

    logic                w_consume;
    logic signed [32:0]  w_sum;
    logic [31:0]         w_mix;
    logic [31:0]         w_mag;
    logic                w_write;
    logic                w_clear;
    logic                w_full;

    assign w_consume            = io_bus.audio_in_available & ~i_pause & ~i_reset;
    assign io_bus.read_audio_in = w_consume;

    assign w_sum = {io_bus.left_channel_audio_in[31], io_bus.left_channel_audio_in}
                 + {io_bus.right_channel_audio_in[31], io_bus.right_channel_audio_in};
    assign w_mix = MONO_MIX ? 32'(w_sum >>> 1) : io_bus.left_channel_audio_in;

    // Most negative value has no positive twin; clamp its magnitude.
    always_comb begin
        w_mag = w_mix;
        if (w_mix == 32'h8000_0000) begin
            w_mag = 32'h7FFF_FFFF;
        end else if (w_mix[31]) begin
            w_mag = -w_mix;
        end
    end

    assign w_full = (r_ptr == {ADDR_W{1'b1}});

    always_comb begin
        w_state_next = r_state;
        w_write      = 1'b0;
        w_clear      = 1'b0;
        unique case (r_state)
            StIdle, StDone: begin
                if (i_start) begin
                    w_state_next = StArmed;
                    w_clear      = 1'b1;
                end
            end
            StArmed: begin
                if (i_start) begin
                    w_clear = 1'b1;
                end else if (i_stop) begin
                    w_state_next = StDone;
                end else if (w_consume && (w_mag >= THRESHOLD)) begin
                    w_write      = 1'b1;
                    w_state_next = w_full ? StDone : StCapture;
                end
            end
            StCapture: begin
                if (i_start) begin
                    w_state_next = StArmed;
                    w_clear      = 1'b1;
                end else if (i_stop) begin
                    w_state_next = StDone;
                end else if (w_consume) begin
                    w_write = 1'b1;
                    if (w_full) begin
                        w_state_next = StDone;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= StIdle;
            r_ptr         <= '0;
            r_mem_address <= '0;
            r_mem_data    <= '0;
            r_mem_wren    <= 1'b0;
            r_count       <= '0;
            r_peak        <= '0;
        end else begin
            r_state    <= w_state_next;
            r_mem_wren <= w_write;
            if (w_clear) begin
                r_ptr   <= '0;
                r_count <= '0;
                r_peak  <= '0;
            end else if (w_write) begin
                r_mem_address <= r_ptr;
                r_mem_data    <= w_mix;
                r_ptr         <= r_ptr + 1'b1;
                r_count       <= r_count + 1'b1;
                if (w_mag > r_peak) begin
                    r_peak <= w_mag;
                end
            end
        end
    end

    assign io_bus.mem_address = r_mem_address;
    assign io_bus.mem_data    = r_mem_data;
    assign io_bus.mem_wren    = r_mem_wren;
    assign o_recording        = (r_state == StArmed) || (r_state == StCapture);
    assign o_done             = (r_state == StDone);
    assign o_sample_count     = r_count;
    assign o_peak             = r_peak;
endmodule
